pio_access_arbiter: RTL
=======================

Name: pio_access_arbiter

Overview:
- Round-robin arbiter sharing one Avalon-MM PIO output-register slave between two requesters.
- Requester 0 is the FX2LP host command path; requester 1 is the on-chip SDR tuning scheduler.
- Each granted request becomes a single-cycle slave access (write, or read with readback), and the arbiter returns an ack pulse to the owner.
- Sits between the requesters and the PIO slave's s1 port (address, chipselect, write_n, writedata, readdata).

Parameters:
- DATA_W, 32, data width of the slave and requester data buses.
- ADDR_W, 2, slave word-address width.
- FIXED_PRI, 0, 1 = requester 0 always wins; 0 = round-robin.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held high until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 word address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  DATA_W  requester 0 read result; valid with ack0 and held until its next ack.
- req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1.
- address  out  ADDR_W  slave address.
- chipselect  out  1  slave select.
- write_n  out  1  slave write strobe, active low.
- writedata  out  DATA_W  slave write data.
- readdata  in  DATA_W  slave read data; combinational, valid in the same cycle as chipselect.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any reqN is high, pick a winner, latch its we/addr/wdata into internal registers, record the owner, go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (exactly one cycle):
  - chipselect=1, address and writedata from the latched values.
  - write_n = ~latched_we.
  - On a read, capture readdata into the owner's rdata register at the end of this cycle.
  - Go to DONE.
- DONE (one cycle):
  - ackN=1 for the owner only.
  - Update the round-robin pointer to the owner.
  - Go to IDLE.
- Latency: req sampled high at IDLE edge N -> bus access in cycle N+1 -> ack in cycle N+2. Minimum 3 cycles per transaction; back-to-back grants are 3 cycles apart.
- Round-robin rule:
  - Both requesting: grant the requester that was not the last owner.
  - Pointer after reset = last owner 1, so requester 0 wins the first tie.
- FIXED_PRI=1: requester 0 always wins ties; requester 1 can starve (documented, intended for debug only).
- Request changes after the latch have no effect on the bus cycle in progress. Dropping req before ack does not abort the transaction; ack is still issued.
- A requester must deassert req in the cycle after ack, or a new transaction is taken. The requester is responsible for this; the arbiter does not filter it.
- Outside ACCESS, the bus is idle: chipselect=0, write_n=1, address=0, writedata=0. Never drive a glitch-free-assumed value.
- Reset values:
  - state IDLE, busy 0, ack0/ack1 0, rdata0/rdata1 0.
  - chipselect 0, write_n 1, address 0, writedata 0.
  - rr pointer = 1.
- Reset mid-transaction (ACCESS or DONE): return to IDLE next cycle.
  - No ack is issued; a pending rdata capture is discarded and rdata is cleared to 0.
  - The bus goes idle in the same cycle reset is sampled.
- Writes never update rdataN. Reads never drive write_n low.
- All outputs are registered.

Test Plan:
- Reset: after 3 cycles of reset=1, check chipselect=0, write_n=1, ack0=ack1=0, rdata0=rdata1=0, busy=0.
- Single write: req0=1, we0=1, addr0=0, wdata0=0xDEADBEEF at cycle N.
  - Cycle N+1: chipselect=1, write_n=0, writedata=0xDEADBEEF.
  - Cycle N+2: ack0=1; ack1 stays 0.
- Read back: model slave returns 0xDEADBEEF at address 0. req1 read of addr1=0 -> ack1 pulse with rdata1=0xDEADBEEF; rdata0 unchanged.
- Contention: req0 and req1 both held high continuously with different write data.
  - Grant order is 0,1,0,1.
  - Acks are spaced 3 cycles apart.
  - Each writedata matches its owner's data.
- Request change after latch: change wdata0 from 0x1 to 0x2 during ACCESS -> writedata=0x1; ack0 still pulses.
- Reset mid-transaction: assert reset in the ACCESS cycle of a read -> next cycle chipselect=0 and no ack pulse. First grant after reset goes to requester 0 when both request.

Source files
------------

// File: rtl/pio_access_arbiter.sv
// Two-requester arbiter in front of a single Avalon-MM PIO s1 port.
// Each grant becomes one bus cycle, and the owner gets an ack pulse on the following cycle.
module pio_access_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 2,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // Handshake: reqN is held high until ackN. ackN is a one-cycle pulse.
    // rdataN is valid with ackN and is held until the next ackN.
    // reqN must drop the cycle after ackN, or it is taken as a new request.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q;
    logic              rr_last_q;
    logic              lat_we_q;
    logic              grant_any;
    logic              grant_sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        grant_any = req0 | req1;
        if (req0 && req1)
            grant_sel = (FIXED_PRI != 0) ? 1'b0 : ~rr_last_q;
        else
            grant_sel = req1;
        sel_we    = grant_sel ? we1    : we0;
        sel_addr  = grant_sel ? addr1  : addr0;
        sel_wdata = grant_sel ? wdata1 : wdata0;

        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // The bus outputs are loaded on the grant edge, so they act as the latched request.
    // The bus returns to idle on every edge that does not start an access.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            lat_we_q   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            busy       <= 1'b0;
        end else begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= '0;
            writedata  <= '0;
            busy       <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        owner_q    <= grant_sel;
                        lat_we_q   <= sel_we;
                        chipselect <= 1'b1;
                        write_n    <= ~sel_we;
                        address    <= sel_addr;
                        writedata  <= sel_wdata;
                    end
                end
                ACCESS: begin
                    if (!lat_we_q) begin
                        if (owner_q) rdata1 <= readdata;
                        else         rdata0 <= readdata;
                    end
                    if (owner_q) ack1 <= 1'b1;
                    else         ack0 <= 1'b1;
                end
                DONE: rr_last_q <= owner_q;
                default: ;
            endcase
        end
    end

    assign state_dbg = state_q;

endmodule
